load_store_unit: RTL and testbench

//  Bridges the core's load/store requests to the word-only, single-port block RAM.
//  - Handles RV32I LB/LH/LW/LBU/LHU/SB/SH/SW.
//  - Loads: extracts and sign/zero-extends sub-words.
//  - Sub-word stores: read-modify-write, because the RAM writes whole words only.
//  - Checks alignment and range before touching memory.
//  - Sits between the core's execute stage and the RAM: mem_addr/mem_wdata/mem_rw/mem_rdata.

---
 rtl/load_store_unit_pkg.sv | 38 +++
 rtl/load_store_unit_if.sv | 29 ++
 rtl/load_store_unit_align.sv | 58 +++++
 rtl/load_store_unit.sv | 126 ++++++++++++
 tb/tb_load_store_unit.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: RV32I funct3 widths, one-hot FSM states
// and the request legality check applied at accept time.
package load_store_unit_pkg;

    localparam int unsigned MEM_WORDS_DEFAULT = 256;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [5:0] {
        ST_IDLE = 6'b000001,
        ST_RD   = 6'b000010,
        ST_EXT  = 6'b000100,
        ST_MRG  = 6'b001000,
        ST_WR   = 6'b010000,
        ST_ERR  = 6'b100000
    } lsu_state_e;

    // True when the request must be rejected without touching the RAM.
    function automatic logic request_error(input logic        we,
                                           input logic [2:0]  funct3,
                                           input logic [31:0] addr,
                                           input int unsigned mem_words);
        logic bad_f3;
        logic misaligned;
        logic out_of_range;
        bad_f3       = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7) ||
                       (we && ((funct3 == F3_BU) || (funct3 == F3_HU)));
        misaligned   = (((funct3 == F3_H) || (funct3 == F3_HU)) && addr[0]) ||
                       ((funct3 == F3_W) && (addr[1:0] != 2'b00));
        out_of_range = ({2'b00, addr[31:2]} >= mem_words);
        return bad_f3 || misaligned || out_of_range;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response and RAM-side port bundle of the load/store unit.
// The slave modport is the unit itself; master is whoever drives requests and models the RAM.
interface load_store_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rw;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_rw
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_rw
    );

endinterface

// File: rtl/load_store_unit_align.sv
// Combinational sub-word datapath: load extraction with sign/zero extension, and the
// store merge that splices a byte/half into the word read back from RAM.
module load_store_unit_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = 8'h00;
        case (off)
            2'd0: sel_byte = word[7:0];
            2'd1: sel_byte = word[15:8];
            2'd2: sel_byte = word[23:16];
            2'd3: sel_byte = word[31:24];
            default: sel_byte = 8'h00;
        endcase
        sel_half = off[1] ? word[31:16] : word[15:0];

        load_data = word;
        case (funct3)
            F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_BU:   load_data = {24'h000000, sel_byte};
            F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
            F3_HU:   load_data = {16'h0000, sel_half};
            default: load_data = word;
        endcase
    end

    // Only SB/SH reach the merge path, so any other funct3 passes the word through.
    always_comb begin
        merged = word;
        if (funct3 == F3_B) begin
            case (off)
                2'd0: merged[7:0]   = wdata[7:0];
                2'd1: merged[15:8]  = wdata[7:0];
                2'd2: merged[23:16] = wdata[7:0];
                2'd3: merged[31:24] = wdata[7:0];
                default: merged = word;
            endcase
        end else if (funct3 == F3_H) begin
            if (off[1]) begin
                merged[31:16] = wdata;
            end else begin
                merged[15:0] = wdata;
            end
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a word-only single-port block RAM;
// sub-word stores are done as read-modify-write.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic                  clk,
    input  logic                  resetn,
    load_store_unit_if.slave      bus
);

    lsu_state_e  state_q, state_d;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] wbuf;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic        accept;
    logic        req_bad;
    logic [31:0] load_data;
    logic [31:0] merged;

    assign accept  = bus.req_valid && (state_q == ST_IDLE);
    assign req_bad = request_error(bus.req_we, bus.req_funct3, bus.req_addr, MEM_WORDS);

    load_store_unit_align u_align (
        .word      (bus.mem_rdata),
        .off       (addr_q[1:0]),
        .funct3    (funct3_q),
        .wdata     (wdata_q[15:0]),
        .load_data (load_data),
        .merged    (merged)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_bad) begin
                        state_d = ST_ERR;
                    end else if (bus.req_we && (bus.req_funct3 == F3_W)) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD:   state_d = we_q ? ST_MRG : ST_EXT;
            ST_EXT:  state_d = ST_IDLE;
            ST_MRG:  state_d = ST_WR;
            ST_WR:   state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Rejected requests respond on the accept edge itself; ERR is then a one-cycle
    // recovery state during which the unit is not ready.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            we_q        <= 1'b0;
            funct3_q    <= 3'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            wbuf        <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (accept) begin
                we_q     <= bus.req_we;
                funct3_q <= bus.req_funct3;
                addr_q   <= bus.req_addr;
                wdata_q  <= bus.req_wdata;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept && req_bad) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= 32'd0;
                    end
                end
                ST_EXT: begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= load_data;
                end
                ST_MRG: begin
                    wbuf <= merged;
                end
                ST_WR: begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= 32'd0;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.mem_rw    = (state_q != ST_WR);
    assign bus.mem_addr  = {addr_q[31:2], 2'b00};
    assign bus.mem_wdata = (funct3_q == F3_W) ? wdata_q : wbuf;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit paired with a behavioural 256-word block RAM
// (MEM[1] = 8899AABB, MEM[255] = 0BADF00D at start).
module tb_load_store_unit;

    logic clk;
    logic resetn;
    int   tests_run;
    int   tests_failed;

    logic [31:0] mem [256];
    logic [31:0] mem_rdata_q;

    load_store_unit_if bus ();

    load_store_unit #(.MEM_WORDS(256)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: writes whenever mem_rw is low, read data appears one edge after the address.
    always @(posedge clk) begin
        if (!bus.mem_rw) begin
            mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
        end
        mem_rdata_q <= mem[bus.mem_addr[9:2]];
    end
    assign bus.mem_rdata = mem_rdata_q;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %08h, expected %08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output int lat, output int low_cycles,
                                 output logic [31:0] rdata, output logic err);
        int n;
        @(negedge clk);
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_valid  = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat = 1;
        low_cycles = 0;
        while (!bus.rsp_valid && lat < 10) begin
            if (!bus.mem_rw) low_cycles++;
            @(posedge clk);
            #1;
            lat++;
        end
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
    endtask

    task automatic runCase(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err,
                           input int exp_lat, input int exp_low);
        int          lat;
        int          low;
        logic [31:0] rdata;
        logic        err;
        applyStimulus(we, f3, addr, wdata, lat, low, rdata, err);
        checkOutput({tag, " rdata"}, rdata, exp_rdata);
        checkOutput({tag, " err"}, {31'd0, err}, {31'd0, exp_err});
        checkOutput({tag, " latency"}, lat, exp_lat);
        checkOutput({tag, " mem_rw low cycles"}, low, exp_low);
    endtask

    initial begin
        int rsp_seen;
        int n;

        tests_run    = 0;
        tests_failed = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[1]   = 32'h8899AABB;
        mem[255] = 32'h0BADF00D;

        resetn         = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset req_ready", {31'd0, bus.req_ready}, 32'd1);
        checkOutput("reset rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        checkOutput("reset rsp_rdata", bus.rsp_rdata, 32'd0);
        checkOutput("reset rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        checkOutput("reset mem_rw", {31'd0, bus.mem_rw}, 32'd1);
        @(negedge clk);
        resetn = 1'b1;

        // Word and sub-word loads from MEM[1] = 8899AABB.
        runCase("LW 0x4",  1'b0, 3'd2, 32'h4, 32'h0, 32'h8899AABB, 1'b0, 3, 0);
        runCase("LB 0x7",  1'b0, 3'd0, 32'h7, 32'h0, 32'hFFFFFF88, 1'b0, 3, 0);
        runCase("LBU 0x7", 1'b0, 3'd4, 32'h7, 32'h0, 32'h00000088, 1'b0, 3, 0);
        runCase("LH 0x6",  1'b0, 3'd1, 32'h6, 32'h0, 32'hFFFF8899, 1'b0, 3, 0);
        runCase("LHU 0x4", 1'b0, 3'd5, 32'h4, 32'h0, 32'h0000AABB, 1'b0, 3, 0);
        runCase("LB 0x5",  1'b0, 3'd0, 32'h5, 32'h0, 32'hFFFFFFAA, 1'b0, 3, 0);

        // Stores: SB/SH read-modify-write, SW direct.
        runCase("SB 0x5", 1'b1, 3'd0, 32'h5, 32'h123456CC, 32'h0, 1'b0, 4, 1);
        checkOutput("SB 0x5 MEM[1]", mem[1], 32'h8899CCBB);
        runCase("SH 0x6", 1'b1, 3'd1, 32'h6, 32'h00001122, 32'h0, 1'b0, 4, 1);
        checkOutput("SH 0x6 MEM[1]", mem[1], 32'h1122CCBB);
        runCase("SW 0x4", 1'b1, 3'd2, 32'h4, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1);
        checkOutput("SW 0x4 MEM[1]", mem[1], 32'hDEADBEEF);

        // Rejected requests: misaligned, illegal funct3, store with unsigned width.
        runCase("LW 0x2 misaligned",  1'b0, 3'd2, 32'h2, 32'h0,        32'h0, 1'b1, 1, 0);
        runCase("SH 0x3 misaligned",  1'b1, 3'd1, 32'h3, 32'h0000FFFF, 32'h0, 1'b1, 1, 0);
        runCase("funct3=3 illegal",   1'b0, 3'd3, 32'h4, 32'h0,        32'h0, 1'b1, 1, 0);
        runCase("SB funct3=4 illegal", 1'b1, 3'd4, 32'h4, 32'h000000FF, 32'h0, 1'b1, 1, 0);
        checkOutput("errors MEM[1]", mem[1], 32'hDEADBEEF);

        // Range boundary: word 256 rejected, word 255 readable and clears rsp_err.
        runCase("LW 0x400 range", 1'b0, 3'd2, 32'h400, 32'h0, 32'h0, 1'b1, 1, 0);
        runCase("LW 0x3FC",       1'b0, 3'd2, 32'h3FC, 32'h0, 32'h0BADF00D, 1'b0, 3, 0);

        // Reset while the SB is in MRG: no write, no response.
        @(negedge clk);
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'h5;
        bus.req_wdata  = 32'h000000FF;
        bus.req_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        rsp_seen = 0;
        @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        checkOutput("abort mem_rw in reset", {31'd0, bus.mem_rw}, 32'd1);
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) rsp_seen++;
        end
        @(negedge clk);
        resetn = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) rsp_seen++;
        end
        checkOutput("abort rsp_valid count", rsp_seen, 0);
        checkOutput("abort MEM[1]", mem[1], 32'hDEADBEEF);
        checkOutput("abort req_ready", {31'd0, bus.req_ready}, 32'd1);

        // Back-to-back: second request held valid and accepted in the first's response cycle.
        @(negedge clk);
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd2;
        bus.req_addr   = 32'h4;
        bus.req_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.req_funct3 = 3'd4;
        bus.req_addr   = 32'h4;
        n = 1;
        while (!bus.rsp_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("b2b first latency", n, 3);
        checkOutput("b2b first rdata", bus.rsp_rdata, 32'hDEADBEEF);
        checkOutput("b2b ready in rsp cycle", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        n = 1;
        while (!bus.rsp_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("b2b second latency", n, 3);
        checkOutput("b2b second rdata", bus.rsp_rdata, 32'h000000EF);
        checkOutput("b2b second err", {31'd0, bus.rsp_err}, 32'd0);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
